// File: rtl/load_n.sv
// Multi-channel sample loader: packs BEATS beats of CHANNELS x WIDTH samples
// into one result word, with flush of partial words and valid/ready output.

module load_n_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end
endmodule

module load_n #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int BEATS    = 2,
  localparam int IN_W    = CHANNELS*WIDTH,
  localparam int OUT_W   = IN_W*BEATS,
  localparam int CW      = $clog2(BEATS+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  s,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [OUT_W-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_beats
);
  typedef enum logic [1:0] {EMPTY, FILL, HOLD} state_t;

  state_t                      state, nxt_state;
  logic [CW-1:0]               cnt, nxt_cnt, eff_cnt;
  logic                        pend, nxt_pend, xfer, accept, out_free;
  logic [BEATS-1:0][IN_W-1:0]  acc, acc_view;
  logic [BEATS-1:0]            slot_we;

  assign in_ready = (state != HOLD) && !pend;
  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign eff_cnt  = cnt + CW'(accept);

  // acc_view is the accumulator as it would look with this cycle's beat in it;
  // a transfer copies it so the completing beat reaches result on the same edge.
  for (genvar j = 0; j < BEATS; j++) begin : g_slot
    assign slot_we[j]  = accept && (cnt == CW'(j));
    assign acc_view[j] = slot_we[j] ? s : acc[j];
    load_n_slot #(.W(IN_W)) u_slot (
      .clk (clk),
      .rst (rst),
      .clr (xfer),
      .we  (slot_we[j]),
      .d   (s),
      .q   (acc[j])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      pend  <= nxt_pend;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_pend  = pend;
    xfer      = 1'b0;
    if (state == HOLD || pend) begin
      // no accepts here, so eff_cnt == cnt
      if (out_free) begin
        xfer      = 1'b1;
        nxt_cnt   = '0;
        nxt_pend  = 1'b0;
        nxt_state = EMPTY;
      end
    end else if (accept && eff_cnt == CW'(BEATS)) begin
      if (out_free) begin
        xfer      = 1'b1;
        nxt_cnt   = '0;
        nxt_state = EMPTY;
      end else begin
        nxt_cnt   = eff_cnt;
        nxt_state = HOLD;
      end
    end else if (flush && eff_cnt != '0) begin
      if (out_free) begin
        xfer      = 1'b1;
        nxt_cnt   = '0;
        nxt_state = EMPTY;
      end else begin
        nxt_cnt   = eff_cnt;
        nxt_pend  = 1'b1;
        nxt_state = FILL;
      end
    end else if (accept) begin
      nxt_cnt   = eff_cnt;
      nxt_state = FILL;
    end
  end

  // Transfers only happen when out_free, so result is stable under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result    <= '0;
      out_beats <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      result    <= acc_view;
      out_beats <= eff_cnt;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_load_n.sv
// Directed bench for load_n at default parameters: vector table plus
// hand-written backpressure, pending-flush and async-reset sequences.

module tb_load_n;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [63:0] result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_beats;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] A = 32'hC0272EF0;
  localparam logic [31:0] B = 32'h01020304;
  localparam logic [31:0] C = 32'hDEADBEEF;

  load_n dut (
    .clk       (clk),
    .rst       (rst),
    .s         (s),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_beats (out_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        fl;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic        cd;
    logic [63:0] res;
    logic [1:0]  nb;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic fl, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    s         = d;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic ov, input logic ir,
                         input logic [63:0] res, input logic [1:0] nb);
    chk({nm, ".out_valid"}, 64'(out_valid), 64'(ov));
    chk({nm, ".in_ready"}, 64'(in_ready), 64'(ir));
    chk({nm, ".result"}, result, res);
    chk({nm, ".out_beats"}, 64'(out_beats), 64'(nb));
  endtask

  initial begin
    //          v  d  fl or  ov ir cd result               nb
    tbl[0]  = '{1, A, 0, 1,  0, 1, 0, 64'h0,               2'd0};
    tbl[1]  = '{1, B, 0, 1,  1, 1, 1, {B, A},              2'd2};
    tbl[2]  = '{0, 0, 0, 1,  0, 1, 0, 64'h0,               2'd0};
    tbl[3]  = '{1, A, 0, 1,  0, 1, 0, 64'h0,               2'd0};
    tbl[4]  = '{0, 0, 1, 1,  1, 1, 1, {32'h0, A},          2'd1};
    tbl[5]  = '{0, 0, 1, 1,  0, 1, 0, 64'h0,               2'd0};
    tbl[6]  = '{0, 0, 0, 1,  0, 1, 0, 64'h0,               2'd0};
    tbl[7]  = '{1, A, 0, 1,  0, 1, 0, 64'h0,               2'd0};
    tbl[8]  = '{1, B, 1, 1,  1, 1, 1, {B, A},              2'd2};
    tbl[9]  = '{1, B, 1, 1,  1, 1, 1, {32'h0, B},          2'd1};
    tbl[10] = '{0, 0, 0, 1,  0, 1, 0, 64'h0,               2'd0};

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset_hold", 1'b0, 1'b1, 64'h0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_out("reset_rel", 1'b0, 1'b1, 64'h0, 2'd0);

    // vector table: basic pack, partial flush, flush + accept
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].ordy);
      chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
      if (tbl[i].cd) begin
        chk($sformatf("vec%0d.result", i), result, tbl[i].res);
        chk($sformatf("vec%0d.out_beats", i), 64'(out_beats), 64'(tbl[i].nb));
      end
    end

    // backpressure: three words, second goes to HOLD
    step(1, 32'h11111111, 0, 0);
    chk("bp1.out_valid", 64'(out_valid), 64'(0));
    step(1, 32'h22222222, 0, 0);
    chk_out("bp2", 1'b1, 1'b1, {32'h22222222, 32'h11111111}, 2'd2);
    step(1, 32'h33333333, 0, 0);
    chk_out("bp3", 1'b1, 1'b1, {32'h22222222, 32'h11111111}, 2'd2);
    step(1, 32'h44444444, 0, 0);
    chk_out("bp4_hold", 1'b1, 1'b0, {32'h22222222, 32'h11111111}, 2'd2);
    step(1, 32'h55555555, 0, 0);
    chk_out("bp5_hold", 1'b1, 1'b0, {32'h22222222, 32'h11111111}, 2'd2);
    step(1, 32'h55555555, 0, 1);
    chk_out("bp_w2", 1'b1, 1'b1, {32'h44444444, 32'h33333333}, 2'd2);
    step(1, 32'h55555555, 0, 1);
    chk("bp_gap.out_valid", 64'(out_valid), 64'(0));
    step(1, 32'h66666666, 0, 1);
    chk_out("bp_w3", 1'b1, 1'b1, {32'h66666666, 32'h55555555}, 2'd2);
    step(0, 0, 0, 1);
    chk("bp_end.out_valid", 64'(out_valid), 64'(0));

    // pending flush under out_ready = 0
    step(1, A, 0, 0);
    step(1, B, 0, 0);
    chk_out("pf_w1", 1'b1, 1'b1, {B, A}, 2'd2);
    step(1, C, 0, 0);
    step(0, 0, 1, 0);
    chk_out("pf_pend", 1'b1, 1'b0, {B, A}, 2'd2);
    step(0, 0, 0, 0);
    chk_out("pf_pend2", 1'b1, 1'b0, {B, A}, 2'd2);
    step(0, 0, 0, 1);
    chk_out("pf_done", 1'b1, 1'b1, {32'h0, C}, 2'd1);
    step(0, 0, 0, 1);
    chk("pf_end.out_valid", 64'(out_valid), 64'(0));

    // async reset while in HOLD
    step(1, 32'h11111111, 0, 0);
    step(1, 32'h22222222, 0, 0);
    step(1, 32'h33333333, 0, 0);
    step(1, 32'h44444444, 0, 0);
    chk("ar_hold.in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_out("ar_async", 1'b0, 1'b1, 64'h0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1, A, 0, 1);
    chk_out("ar_b1", 1'b0, 1'b1, 64'h0, 2'd0);
    step(1, B, 0, 1);
    chk_out("ar_w", 1'b1, 1'b1, {B, A}, 2'd2);
    step(0, 0, 0, 1);
    chk("ar_end.out_valid", 64'(out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
